// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        READY   = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INSN = 32'h0000_0000;
    localparam logic [3:0]  WB_SEL_WORD = 4'b1111;

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk, reset : clock, asynchronous active-high reset (pc <= RESET_VAL)
//   load       : load load_val (highest priority)
//   inc        : advance pc by one word, wrapping at 2^ADDR_WIDTH
//   pc         : current program counter
module pc_reg #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VAL  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + WORD_STEP;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetches one instruction per
// request over a classic Wishbone read-only master.
//   clk, reset        : clock, asynchronous active-high reset
//   wbm_*             : Wishbone classic master (cyc/stb/adr/sel/we out, ack/dat in)
//   stall_i           : presented instruction is not consumed this cycle
//   redirect_i/_pc_i  : taken branch/jump, refetch from word-aligned target
//   if_pc             : PC of presented instruction
//   if_instruction    : presented instruction, bubble when not valid
//   if_valid          : if_pc/if_instruction hold a fetched, undiscarded instruction
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    input  logic                  wbm_ack_i,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic [3:0]            wbm_sel_o,
    output logic                  wbm_we_o,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instruction,
    output logic                  if_valid
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] BUBBLE     = DATA_WIDTH'(BUBBLE_INSN);

    fetch_state_t          state;
    logic                  cyc;
    logic                  redirect_pending;
    logic [ADDR_WIDTH-1:0] pending_pc;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] redirect_tgt;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_val;
    logic                  pc_inc;

    assign redirect_tgt = redirect_pc_i & ALIGN_MASK;

    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_adr_o = pc;
    assign wbm_sel_o = WB_SEL_WORD;
    assign wbm_we_o  = 1'b0;

    // PC update selection; a redirect arriving on the ack cycle beats an older pending one.
    always_comb begin
        pc_load     = 1'b0;
        pc_load_val = redirect_tgt;
        pc_inc      = 1'b0;
        unique case (state)
            IDLE, DISCARD: begin
                pc_load = redirect_i;
            end
            FETCH: begin
                if (wbm_ack_i) begin
                    if (redirect_i) begin
                        pc_load = 1'b1;
                    end else if (redirect_pending) begin
                        pc_load     = 1'b1;
                        pc_load_val = pending_pc;
                    end
                end
            end
            READY: begin
                if (redirect_i) begin
                    pc_load = 1'b1;
                end else if (!stall_i) begin
                    pc_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_VAL  (PC_ADDR)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // Fetch FSM with registered bus strobe and IF/ID-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cyc              <= 1'b0;
            redirect_pending <= 1'b0;
            pending_pc       <= PC_ADDR;
            if_pc            <= PC_ADDR;
            if_instruction   <= BUBBLE;
            if_valid         <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DISCARD: begin
                    state <= FETCH;
                    cyc   <= 1'b1;
                end
                FETCH: begin
                    if (wbm_ack_i) begin
                        cyc              <= 1'b0;
                        redirect_pending <= 1'b0;
                        // Data fetched under a stale PC is dropped.
                        if (redirect_i || redirect_pending) begin
                            state <= DISCARD;
                        end else begin
                            state          <= READY;
                            if_pc          <= pc;
                            if_instruction <= wbm_dat_i;
                            if_valid       <= 1'b1;
                        end
                    end else if (redirect_i) begin
                        // Classic cycles cannot be aborted; remember the target.
                        redirect_pending <= 1'b1;
                        pending_pc       <= redirect_tgt;
                    end
                end
                READY: begin
                    if (redirect_i || !stall_i) begin
                        state          <= FETCH;
                        cyc            <= 1'b1;
                        if_valid       <= 1'b0;
                        if_instruction <= BUBBLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc   <= 1'b0;
                end
            endcase
        end
    end

endmodule
